serdes_lock_align: RTL and testbench
====================================

# serdes_lock_align

Receive-side bring-up controller for the SERDES assembly. It sits directly downstream of the `xpll` clock generator and runs in its divided-clock domain. It waits for the PLL lock to be stable, sequences the ISERDES reset, then trains word alignment by issuing BITSLIP pulses until the parallel data matches a fixed training pattern. It reports aligned or failed to the link layer.

## Interface
Parameters:
- `DATA_W`, 8: ISERDES parallel word width.
- `TRAIN_PAT`, 8'h5C: training word expected on `RX_DATA` when aligned. Width is `DATA_W`.
- `LOCK_SYNC`, 2: synchronizer depth for `PLL_LOCKED`. Minimum 2.
- `LOCK_STABLE`, 64: consecutive synchronized-lock cycles required before reset release begins.
- `RST_HOLD`, 16: cycles `SERDES_RST` is held after lock is stable.
- `SLIP_GAP`, 4: settle cycles after reset release or after each BITSLIP, before data is compared.
- `MATCH_CNT`, 16: consecutive matching words required to declare alignment.

Ports:
- `CLK_IN`  in  1: divided clock (PLL_CLK_DIV). Single clock for the whole block.
- `RST_N`  in  1: asynchronous, active-low reset.
- `PLL_LOCKED`  in  1: PLL lock. Asynchronous to `CLK_IN`; synchronized internally.
- `RX_DATA`  in  `DATA_W`: parallel word from the ISERDES.
- `RETRAIN`  in  1: single-cycle request to redo reset and alignment. Honoured only in ALIGNED or FAIL.
- `SERDES_RST`  out  1: ISERDES reset, active high.
- `BITSLIP`  out  1: single-cycle bitslip pulse.
- `ALIGNED`  out  1: alignment achieved.
- `ALIGN_FAIL`  out  1: all `DATA_W` positions were tried without a match.
- `SLIP_CNT`  out  `$clog2(DATA_W)+1`: number of BITSLIPs issued in the current training attempt.

## Operation
- All outputs are registered and decoded from the next state, so each output is valid in the same cycle its state is entered.
- Reset values: `SERDES_RST`=1, `BITSLIP`=0, `ALIGNED`=0, `ALIGN_FAIL`=0, `SLIP_CNT`=0. State resets to WAIT_LOCK. All counters reset to 0.
- The FSM has seven states:
  - WAIT_LOCK: `SERDES_RST`=1. `lock_s` is `PLL_LOCKED` after the `LOCK_SYNC` flops. The stable counter increments while `lock_s`=1 and clears when `lock_s`=0. When it reaches `LOCK_STABLE`, go to HOLD.
  - HOLD: `SERDES_RST`=1 for exactly `RST_HOLD` cycles. `SLIP_CNT` is cleared on entry. Then go to SETTLE.
  - SETTLE: `SERDES_RST`=0. Wait `SLIP_GAP` cycles, then go to CHECK with the match counter cleared.
  - CHECK: when `RX_DATA`==`TRAIN_PAT`, the match counter increments; at `MATCH_CNT` go to ALIGNED. On any mismatch, go to SLIP if `SLIP_CNT` < `DATA_W`-1, otherwise go to FAIL.
  - SLIP: `BITSLIP`=1 for exactly one cycle and `SLIP_CNT` increments. Then go to SETTLE.
  - ALIGNED: `ALIGNED`=1 and is held. Later mismatches are ignored. `RETRAIN`=1 goes to HOLD.
  - FAIL: `ALIGN_FAIL`=1 and is held. `RETRAIN`=1 goes to HOLD.
- Lock loss: `lock_s`=0 in any state other than WAIT_LOCK forces WAIT_LOCK on the next edge. This takes priority over `RETRAIN`, a match, or a slip.
- Lock loss in SLIP still produces the already-registered one-cycle BITSLIP pulse. No further pulse follows.
- `RETRAIN` asserted in any state other than ALIGNED or FAIL is ignored and not stored.
- A match in CHECK on the same cycle the match counter reaches `MATCH_CNT` goes to ALIGNED. A single mismatch restarts the process via SLIP; the match counter is not retained.
- `SLIP_CNT` never exceeds `DATA_W`-1 and never wraps.

## Timing
- The first edge that samples `PLL_LOCKED`=1 is edge 0, with the line held high. `SERDES_RST` falls at edge `LOCK_SYNC`+`LOCK_STABLE`+`RST_HOLD`. With defaults this is 82.
- With an aligned stream, `ALIGNED` rises `SLIP_GAP`+`MATCH_CNT` cycles after `SERDES_RST` falls. With defaults this is 20.
- Each slip costs 1+`SLIP_GAP` cycles, plus the cycles spent in CHECK before the mismatch.
- `BITSLIP` pulses are separated by at least `SLIP_GAP`+1 low cycles.
- After `PLL_LOCKED` falls, `SERDES_RST`=1 and `ALIGNED`=0 within `LOCK_SYNC`+1 cycles.

## Structure
- Shared package `serdes_pkg` holds:
  - the FSM state enum `aln_state_t` (WAIT_LOCK, HOLD, SETTLE, CHECK, SLIP, ALIGNED, FAIL);
  - the default `TRAIN_PAT` constant, which is shared with the TX pattern generator.
- Sub-module `sync_bit` is a `LOCK_SYNC`-deep flop chain with asynchronous active-low reset to 0. It is reused for other asynchronous status inputs.
- The remainder is one FSM with three counters: stable, hold/settle (shared), and match.

## Test plan
Defaults apply throughout. The bench ISERDES model rotates its word by one bit per BITSLIP.
- Reset: `RST_N`=0 with `PLL_LOCKED`=1 → `SERDES_RST`=1, all other outputs 0, and this persists until `RST_N` rises.
- Lock glitch: `PLL_LOCKED` high 40 cycles, low 1 cycle, then high → `SERDES_RST` still 1 at the glitch, and falls exactly 82 edges after the final rise.
- Offset 5: the model needs 5 slips → exactly 5 one-cycle BITSLIP pulses spaced ≥5 cycles apart, then `SLIP_CNT`=5 and `ALIGNED`=1.
- No pattern: `RX_DATA`=8'h00 constant → exactly 7 BITSLIP pulses, then `ALIGN_FAIL`=1, `SLIP_CNT`=7, `ALIGNED`=0.
- Mismatch on the 10th CHECK word at offset 0 → one BITSLIP, `SLIP_CNT`=1, then training continues.
- Lock loss in ALIGNED → `ALIGNED`=0 and `SERDES_RST`=1 within 3 cycles.
- `RETRAIN` in ALIGNED → `SERDES_RST`=1 for 16 cycles, `SLIP_CNT`=0, then realignment.

Source files
------------

// File: rtl/serdes_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================
// Package : serdes_pkg
// Brief   : Shared types and constants for the SERDES receive/transmit path.
// Rev     : 1.0
// ============================================================
package serdes_pkg;

    typedef enum logic [2:0] {
        S_WAIT_LOCK = 3'd0,
        S_HOLD      = 3'd1,
        S_SETTLE    = 3'd2,
        S_CHECK     = 3'd3,
        S_SLIP      = 3'd4,
        S_ALIGNED   = 3'd5,
        S_FAIL      = 3'd6
    } aln_state_t;

    // Training word shared with the TX pattern generator.
    localparam logic [7:0] TRAIN_PAT_DEFAULT = 8'h5C;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_bit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================
// Module : sync_bit
// Brief  : DEPTH-stage flop chain bringing an asynchronous status bit into clk.
// Rev    : 1.0
// ============================================================
module sync_bit #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] r_chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[DEPTH-2:0], d};
        end
    end

    assign q = r_chain[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/serdes_lock_align.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================
// Module : serdes_lock_align
// Brief  : PLL lock qualification, ISERDES reset sequencing and bitslip word alignment.
// Rev    : 1.0
// ============================================================
module serdes_lock_align
    import serdes_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter logic [DATA_W-1:0] TRAIN_PAT   = DATA_W'(TRAIN_PAT_DEFAULT),
    parameter int                LOCK_SYNC   = 2,
    parameter int                LOCK_STABLE = 64,
    parameter int                RST_HOLD    = 16,
    parameter int                SLIP_GAP    = 4,
    parameter int                MATCH_CNT   = 16
) (
    input  logic                      CLK_IN,
    input  logic                      RST_N,
    input  logic                      PLL_LOCKED,
    input  logic [DATA_W-1:0]         RX_DATA,
    input  logic                      RETRAIN,
    output logic                      SERDES_RST,
    output logic                      BITSLIP,
    output logic                      ALIGNED,
    output logic                      ALIGN_FAIL,
    output logic [$clog2(DATA_W):0]   SLIP_CNT
);

    localparam int SC_W = $clog2(DATA_W) + 1;
    localparam int ST_W = $clog2(LOCK_STABLE + 1);
    localparam int HS_W = $clog2(max_int(RST_HOLD, SLIP_GAP) + 1);
    localparam int MC_W = $clog2(MATCH_CNT + 1);

    localparam logic [ST_W-1:0] C_STABLE_DONE = ST_W'(LOCK_STABLE);
    localparam logic [HS_W-1:0] C_HOLD_LAST   = HS_W'(RST_HOLD - 1);
    localparam logic [HS_W-1:0] C_GAP_LAST    = HS_W'(SLIP_GAP - 1);
    localparam logic [MC_W-1:0] C_MATCH_LAST  = MC_W'(MATCH_CNT - 1);
    localparam logic [SC_W-1:0] C_SLIP_LAST   = SC_W'(DATA_W - 1);

    aln_state_t      r_state;
    aln_state_t      w_next;
    logic            w_lock_s;
    logic            w_match;
    logic [ST_W-1:0] r_stable_cnt;
    logic [HS_W-1:0] r_hs_cnt;
    logic [MC_W-1:0] r_match_cnt;
    logic [SC_W-1:0] r_slip_cnt;
    logic            w_serdes_rst;
    logic            w_bitslip;
    logic            w_aligned;
    logic            w_align_fail;

    sync_bit #(
        .DEPTH (LOCK_SYNC)
    ) u_lock_sync (
        .clk   (CLK_IN),
        .rst_n (RST_N),
        .d     (PLL_LOCKED),
        .q     (w_lock_s)
    );

    assign w_match = (RX_DATA == TRAIN_PAT);

    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_WAIT_LOCK;
        end else begin
            r_state <= w_next;
        end
    end

    // Lock loss outranks every other transition, including RETRAIN.
    always_comb begin
        w_next = r_state;
        if ((r_state != S_WAIT_LOCK) && !w_lock_s) begin
            w_next = S_WAIT_LOCK;
        end else begin
            case (r_state)
                S_WAIT_LOCK: begin
                    if (w_lock_s && (r_stable_cnt == C_STABLE_DONE)) w_next = S_HOLD;
                end
                S_HOLD: begin
                    if (r_hs_cnt == C_HOLD_LAST) w_next = S_SETTLE;
                end
                S_SETTLE: begin
                    if (r_hs_cnt == C_GAP_LAST) w_next = S_CHECK;
                end
                S_CHECK: begin
                    if (w_match) begin
                        if (r_match_cnt == C_MATCH_LAST) w_next = S_ALIGNED;
                    end else if (r_slip_cnt < C_SLIP_LAST) begin
                        w_next = S_SLIP;
                    end else begin
                        w_next = S_FAIL;
                    end
                end
                S_SLIP:    w_next = S_SETTLE;
                S_ALIGNED,
                S_FAIL: begin
                    if (RETRAIN) w_next = S_HOLD;
                end
                default:   w_next = S_WAIT_LOCK;
            endcase
        end
    end

    always_comb begin
        w_serdes_rst = (w_next == S_WAIT_LOCK) || (w_next == S_HOLD);
        w_bitslip    = (w_next == S_SLIP);
        w_aligned    = (w_next == S_ALIGNED);
        w_align_fail = (w_next == S_FAIL);
    end

    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            SERDES_RST <= 1'b1;
            BITSLIP    <= 1'b0;
            ALIGNED    <= 1'b0;
            ALIGN_FAIL <= 1'b0;
        end else begin
            SERDES_RST <= w_serdes_rst;
            BITSLIP    <= w_bitslip;
            ALIGNED    <= w_aligned;
            ALIGN_FAIL <= w_align_fail;
        end
    end

    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            r_stable_cnt <= '0;
        end else if (!w_lock_s) begin
            r_stable_cnt <= '0;
        end else if (r_stable_cnt != C_STABLE_DONE) begin
            r_stable_cnt <= r_stable_cnt + 1'b1;
        end
    end

    // HOLD and SETTLE never overlap, so one counter times both; it restarts on every state change.
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            r_hs_cnt <= '0;
        end else if (w_next != r_state) begin
            r_hs_cnt <= '0;
        end else if ((r_state == S_HOLD) || (r_state == S_SETTLE)) begin
            r_hs_cnt <= r_hs_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            r_match_cnt <= '0;
        end else if ((r_state == S_CHECK) && w_match) begin
            r_match_cnt <= r_match_cnt + 1'b1;
        end else begin
            r_match_cnt <= '0;
        end
    end

    // SLIP is only entered below the last position, so the count cannot wrap.
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            r_slip_cnt <= '0;
        end else if ((w_next == S_HOLD) && (r_state != S_HOLD)) begin
            r_slip_cnt <= '0;
        end else if ((w_next == S_SLIP) && (r_state != S_SLIP)) begin
            r_slip_cnt <= r_slip_cnt + 1'b1;
        end
    end

    assign SLIP_CNT = r_slip_cnt;

endmodule
`default_nettype wire

// File: tb/tb_serdes_lock_align.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================
// Module : tb_serdes_lock_align
// Brief  : Directed bench for serdes_lock_align with a rotating ISERDES word model.
// Rev    : 1.0
// ============================================================
module tb_serdes_lock_align;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       retrain;
    logic [7:0] rx_data;
    logic       serdes_rst;
    logic       bitslip;
    logic       aligned;
    logic       align_fail;
    logic [3:0] slip_cnt;

    int checks = 0;
    int errors = 0;
    int offset = 0;
    bit zero_mode = 1'b0;
    int model_slips = 0;

    serdes_lock_align dut (
        .CLK_IN     (clk),
        .RST_N      (rst_n),
        .PLL_LOCKED (pll_locked),
        .RX_DATA    (rx_data),
        .RETRAIN    (retrain),
        .SERDES_RST (serdes_rst),
        .BITSLIP    (bitslip),
        .ALIGNED    (aligned),
        .ALIGN_FAIL (align_fail),
        .SLIP_CNT   (slip_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rotl(input logic [7:0] v, input int k);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < k; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // ISERDES model: each BITSLIP rotates the word one bit; aligned when slips == offset.
    always @(posedge clk) begin
        if (!rst_n || serdes_rst) model_slips <= 0;
        else if (bitslip)         model_slips <= model_slips + 1;
    end

    always_comb begin
        rx_data = zero_mode ? 8'h00 : rotl(8'h5C, (model_slips - offset + 8) % 8);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_retrain();
        retrain = 1'b1;
        step(1);
        retrain = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pll_locked = 1'b1; retrain = 1'b0; offset = 0; zero_mode = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            checks++;
            if (serdes_rst !== 1'b1 || bitslip !== 1'b0 || aligned !== 1'b0 ||
                align_fail !== 1'b0 || slip_cnt !== 4'd0) begin
                errors++;
                $display("FAIL reset_values: rst=%b slip=%b al=%b fail=%b cnt=%0d, expected 1 0 0 0 0",
                         serdes_rst, bitslip, aligned, align_fail, slip_cnt);
            end
        end
        pll_locked = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(5);
        checks++;
        if (serdes_rst !== 1'b1) begin
            errors++;
            $display("FAIL reset_no_lock: serdes_rst=%b expected 1", serdes_rst);
        end
    endtask

    task automatic test_lock_glitch();
        bit seen_low;
        pll_locked = 1'b1;
        step(40);
        pll_locked = 1'b0;
        step(1);
        checks++;
        if (serdes_rst !== 1'b1) begin
            errors++;
            $display("FAIL glitch_rst: serdes_rst=%b expected 1", serdes_rst);
        end
        pll_locked = 1'b1;
        seen_low = 1'b0;
        for (int i = 0; i < 82; i++) begin
            step(1);
            if (serdes_rst !== 1'b1) seen_low = 1'b1;
        end
        checks++;
        if (seen_low) begin
            errors++;
            $display("FAIL glitch_early_release: serdes_rst fell before edge 82, expected 1 through edge 81");
        end
        step(1);
        checks++;
        if (serdes_rst !== 1'b0) begin
            errors++;
            $display("FAIL glitch_release: serdes_rst=%b at edge 82, expected 0", serdes_rst);
        end
    endtask

    task automatic test_align_offset0();
        step(19);
        checks++;
        if (aligned !== 1'b0) begin
            errors++;
            $display("FAIL offset0_early: aligned=%b at +19, expected 0", aligned);
        end
        step(1);
        checks++;
        if (aligned !== 1'b1 || slip_cnt !== 4'd0 || bitslip !== 1'b0) begin
            errors++;
            $display("FAIL offset0_aligned: aligned=%b cnt=%0d slip=%b at +20, expected 1 0 0",
                     aligned, slip_cnt, bitslip);
        end
    endtask

    task automatic test_retrain();
        pulse_retrain();
        checks++;
        if (serdes_rst !== 1'b1 || aligned !== 1'b0 || slip_cnt !== 4'd0) begin
            errors++;
            $display("FAIL retrain_entry: rst=%b al=%b cnt=%0d, expected 1 0 0", serdes_rst, aligned, slip_cnt);
        end
        step(5);
        pulse_retrain();
        step(9);
        checks++;
        if (serdes_rst !== 1'b1) begin
            errors++;
            $display("FAIL retrain_hold: serdes_rst=%b at hold cycle 15, expected 1", serdes_rst);
        end
        step(1);
        checks++;
        if (serdes_rst !== 1'b0) begin
            errors++;
            $display("FAIL retrain_release: serdes_rst=%b after 16 hold cycles, expected 0", serdes_rst);
        end
        step(20);
        checks++;
        if (aligned !== 1'b1 || slip_cnt !== 4'd0) begin
            errors++;
            $display("FAIL retrain_realign: aligned=%b cnt=%0d, expected 1 0", aligned, slip_cnt);
        end
    endtask

    task automatic test_offset5();
        int pulses, last, min_gap, t_al;
        bit wide;
        offset = 5;
        step(3);
        checks++;
        if (aligned !== 1'b1) begin
            errors++;
            $display("FAIL aligned_hold: aligned=%b after data change, expected 1", aligned);
        end
        pulse_retrain();
        step(16);
        pulses = 0; last = -100; min_gap = 1000; t_al = -1; wide = 1'b0;
        for (int t = 1; t <= 200 && t_al < 0; t++) begin
            step(1);
            if (bitslip) begin
                if (t == last + 1) wide = 1'b1;
                if (pulses > 0 && (t - last - 1) < min_gap) min_gap = t - last - 1;
                pulses++;
                last = t;
            end
            if (aligned) t_al = t;
        end
        checks++;
        if (pulses != 5 || wide || min_gap < 5) begin
            errors++;
            $display("FAIL offset5_pulses: count=%0d wide=%b min_gap=%0d, expected 5 0 >=5", pulses, wide, min_gap);
        end
        checks++;
        if (t_al != 50) begin
            errors++;
            $display("FAIL offset5_time: aligned at +%0d, expected +50", t_al);
        end
        checks++;
        if (slip_cnt !== 4'd5 || align_fail !== 1'b0) begin
            errors++;
            $display("FAIL offset5_cnt: cnt=%0d fail=%b, expected 5 0", slip_cnt, align_fail);
        end
    endtask

    task automatic test_no_pattern();
        int pulses, t_fail;
        zero_mode = 1'b1;
        pulse_retrain();
        step(16);
        pulses = 0; t_fail = -1;
        for (int t = 1; t <= 200 && t_fail < 0; t++) begin
            step(1);
            if (bitslip) pulses++;
            if (align_fail) t_fail = t;
        end
        checks++;
        if (pulses != 7 || t_fail != 47) begin
            errors++;
            $display("FAIL nopat_fail: pulses=%0d fail_at=+%0d, expected 7 +47", pulses, t_fail);
        end
        checks++;
        if (slip_cnt !== 4'd7 || aligned !== 1'b0) begin
            errors++;
            $display("FAIL nopat_cnt: cnt=%0d aligned=%b, expected 7 0", slip_cnt, aligned);
        end
        pulses = 0;
        for (int t = 0; t < 10; t++) begin
            step(1);
            if (bitslip || !align_fail) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL nopat_hold: %0d cycles with slip or fail dropped, expected 0", pulses);
        end
    endtask

    task automatic test_mismatch10();
        zero_mode = 1'b0;
        offset = 0;
        pulse_retrain();
        step(16);
        step(13);
        checks++;
        if (bitslip !== 1'b0 || aligned !== 1'b0) begin
            errors++;
            $display("FAIL mm10_pre: slip=%b aligned=%b after 9 matches, expected 0 0", bitslip, aligned);
        end
        offset = 1;
        step(1);
        checks++;
        if (bitslip !== 1'b1 || slip_cnt !== 4'd1) begin
            errors++;
            $display("FAIL mm10_slip: slip=%b cnt=%0d, expected 1 1", bitslip, slip_cnt);
        end
        step(1);
        checks++;
        if (bitslip !== 1'b0) begin
            errors++;
            $display("FAIL mm10_pulse_width: slip=%b, expected 0", bitslip);
        end
        step(19);
        checks++;
        if (aligned !== 1'b0) begin
            errors++;
            $display("FAIL mm10_early: aligned=%b, expected 0", aligned);
        end
        step(1);
        checks++;
        if (aligned !== 1'b1 || slip_cnt !== 4'd1) begin
            errors++;
            $display("FAIL mm10_aligned: aligned=%b cnt=%0d, expected 1 1", aligned, slip_cnt);
        end
    endtask

    task automatic test_lock_loss();
        pll_locked = 1'b0;
        offset = 0;
        step(3);
        checks++;
        if (serdes_rst !== 1'b1 || aligned !== 1'b0) begin
            errors++;
            $display("FAIL lockloss: rst=%b aligned=%b after 3 cycles, expected 1 0", serdes_rst, aligned);
        end
        pll_locked = 1'b1;
        step(82);
        checks++;
        if (serdes_rst !== 1'b1) begin
            errors++;
            $display("FAIL relock_hold: serdes_rst=%b at edge 81, expected 1", serdes_rst);
        end
        step(1);
        checks++;
        if (serdes_rst !== 1'b0) begin
            errors++;
            $display("FAIL relock_release: serdes_rst=%b at edge 82, expected 0", serdes_rst);
        end
        step(20);
        checks++;
        if (aligned !== 1'b1 || slip_cnt !== 4'd0) begin
            errors++;
            $display("FAIL relock_align: aligned=%b cnt=%0d, expected 1 0", aligned, slip_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_lock_glitch();
        test_align_offset0();
        test_retrain();
        test_offset5();
        test_no_pattern();
        test_mismatch10();
        test_lock_loss();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within 200000 ns");
        $fatal(1);
    end

endmodule
`default_nettype wire
